// File: rtl/cpu_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_decoder
//
// Main control decoder for the single-issue MIPS-subset CPU. Turns the
// opcode / funct / rt fields of the current instruction into registered mux
// selects and write enables for the PC, ALU, memories, register file and the
// HI/LO/temp registers. Holds no datapath state: one combinational decode
// stage feeding one output register stage.
//
// Ports
//   clk                  in   1  clock, all outputs update on the rising edge
//   rst                  in   1  synchronous active-high reset, clears all outputs
//   opcode               in   6  instr[31:26]
//   funct                in   6  instr[5:0]
//   rt                   in   6  rt field, zero-extended (rt[5] ignored)
//   ctl_pcValue_mux      out  5  one-hot: PC+4, cond branch, jump, rs, trap vector
//   ctl_instRam_en       out  1  fetch enable
//   ctl_instRam_wen      out  1  instruction RAM write (tied low)
//   ctl_aluSrc1_mux      out  3  one-hot: rs, shamt, const 16
//   ctl_aluSrc2_mux      out  4  one-hot: rt, sign-ext imm, zero-ext imm, const 0
//   ctl_alu_mux          out  9  one-hot: ADD SUB SLT SLTU AND OR XOR NOR SLL
//   ctl_dataRam_en       out  1  data RAM access
//   ctl_dataRam_wen      out  1  data RAM write
//   ctl_rfWriteData_mux  out  3  binary: 0 ALU, 1 data RAM, 2 PC+8, 3 HI, 4 LO
//   ctl_rfWriteAddr_mux  out  3  one-hot: rd, rt, $31
//   ctl_rf_wen           out  1  register file write
//   ctl_low_wen          out  1  LO write
//   ctl_high_wen         out  1  HI write
//   ctl_temp_wen         out  1  temp (load data) register write
//
// Configuration macro
//   CPU_DEC_TRAP_EN  defined  : reserved encodings, SYSCALL and BREAK select
//                               the trap vector with every enable low.
//                    undefined: those encodings decode as a NOP.
// ---------------------------------------------------------------------------
module cpu_ctrl_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [5:0] rt,
    output logic [4:0] ctl_pcValue_mux,
    output logic       ctl_instRam_en,
    output logic       ctl_instRam_wen,
    output logic [2:0] ctl_aluSrc1_mux,
    output logic [3:0] ctl_aluSrc2_mux,
    output logic [8:0] ctl_alu_mux,
    output logic       ctl_dataRam_en,
    output logic       ctl_dataRam_wen,
    output logic [2:0] ctl_rfWriteData_mux,
    output logic [2:0] ctl_rfWriteAddr_mux,
    output logic       ctl_rf_wen,
    output logic       ctl_low_wen,
    output logic       ctl_high_wen,
    output logic       ctl_temp_wen
);

    // PC source selects
    localparam logic [4:0] PC_PLUS4  = 5'b00001;
    localparam logic [4:0] PC_BRANCH = 5'b00010;
    localparam logic [4:0] PC_JUMP   = 5'b00100;
    localparam logic [4:0] PC_RS     = 5'b01000;
    localparam logic [4:0] PC_TRAP   = 5'b10000;

    // ALU operand selects
    localparam logic [2:0] SRC1_RS    = 3'b001;
    localparam logic [2:0] SRC1_SHAMT = 3'b010;
    localparam logic [2:0] SRC1_C16   = 3'b100;
    localparam logic [3:0] SRC2_RT    = 4'b0001;
    localparam logic [3:0] SRC2_SEXT  = 4'b0010;
    localparam logic [3:0] SRC2_ZEXT  = 4'b0100;
    localparam logic [3:0] SRC2_ZERO  = 4'b1000;

    // ALU operations
    localparam logic [8:0] ALU_ADD  = 9'h001;
    localparam logic [8:0] ALU_SUB  = 9'h002;
    localparam logic [8:0] ALU_SLT  = 9'h004;
    localparam logic [8:0] ALU_SLTU = 9'h008;
    localparam logic [8:0] ALU_AND  = 9'h010;
    localparam logic [8:0] ALU_OR   = 9'h020;
    localparam logic [8:0] ALU_XOR  = 9'h040;
    localparam logic [8:0] ALU_NOR  = 9'h080;
    localparam logic [8:0] ALU_SLL  = 9'h100;

    // Register file write data / address selects
    localparam logic [2:0] WD_ALU  = 3'd0;
    localparam logic [2:0] WD_MEM  = 3'd1;
    localparam logic [2:0] WD_PC8  = 3'd2;
    localparam logic [2:0] WD_HI   = 3'd3;
    localparam logic [2:0] WD_LO   = 3'd4;
    localparam logic [2:0] WA_RD   = 3'b001;
    localparam logic [2:0] WA_RT   = 3'b010;
    localparam logic [2:0] WA_R31  = 3'b100;

    // rt[5] exists only because the field is delivered zero-extended.
    logic unusedRt;
    assign unusedRt = rt[5];

    logic [4:0] pcValue_p0;
    logic [2:0] aluSrc1_p0;
    logic [3:0] aluSrc2_p0;
    logic [8:0] alu_p0;
    logic       dataRamEn_p0;
    logic       dataRamWen_p0;
    logic [2:0] rfWriteData_p0;
    logic [2:0] rfWriteAddr_p0;
    logic       rfWen_p0;
    logic       lowWen_p0;
    logic       highWen_p0;
    logic       tempWen_p0;
    logic       reserved_p0;

    // ---- stage p0: combinational decode of opcode/funct/rt ----
    always_comb begin
        pcValue_p0     = PC_PLUS4;
        aluSrc1_p0     = '0;
        aluSrc2_p0     = '0;
        alu_p0         = '0;
        dataRamEn_p0   = 1'b0;
        dataRamWen_p0  = 1'b0;
        rfWriteData_p0 = WD_ALU;
        rfWriteAddr_p0 = '0;
        rfWen_p0       = 1'b0;
        lowWen_p0      = 1'b0;
        highWen_p0     = 1'b0;
        tempWen_p0     = 1'b0;
        reserved_p0    = 1'b0;

        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: begin
                        // SLL; the all-zero NOP lands here too and is harmless
                        // because it writes $0.
                        aluSrc1_p0     = SRC1_SHAMT;
                        aluSrc2_p0     = SRC2_RT;
                        alu_p0         = ALU_SLL;
                        rfWriteAddr_p0 = WA_RD;
                        rfWen_p0       = 1'b1;
                    end
                    6'h08: pcValue_p0 = PC_RS;
                    6'h09: begin
                        pcValue_p0     = PC_RS;
                        rfWriteData_p0 = WD_PC8;
                        rfWriteAddr_p0 = WA_RD;
                        rfWen_p0       = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        rfWriteData_p0 = funct[1] ? WD_LO : WD_HI;
                        rfWriteAddr_p0 = WA_RD;
                        rfWen_p0       = 1'b1;
                    end
                    6'h11: highWen_p0 = 1'b1;
                    6'h13: lowWen_p0  = 1'b1;
                    6'h18, 6'h19: begin
                        // Multiplier picks signedness from funct[0] itself.
                        highWen_p0 = 1'b1;
                        lowWen_p0  = 1'b1;
                    end
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        aluSrc1_p0     = SRC1_RS;
                        aluSrc2_p0     = SRC2_RT;
                        rfWriteAddr_p0 = WA_RD;
                        rfWen_p0       = 1'b1;
                        case (funct)
                            6'h20, 6'h21: alu_p0 = ALU_ADD;
                            6'h22, 6'h23: alu_p0 = ALU_SUB;
                            6'h24:        alu_p0 = ALU_AND;
                            6'h25:        alu_p0 = ALU_OR;
                            6'h26:        alu_p0 = ALU_XOR;
                            6'h27:        alu_p0 = ALU_NOR;
                            6'h2A:        alu_p0 = ALU_SLT;
                            default:      alu_p0 = ALU_SLTU;
                        endcase
                    end
                    // SYSCALL, BREAK and unassigned functs
                    default: reserved_p0 = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt[4:0])
                    5'h00, 5'h01, 5'h10, 5'h11: begin
                        pcValue_p0 = PC_BRANCH;
                        aluSrc1_p0 = SRC1_RS;
                        aluSrc2_p0 = SRC2_ZERO;
                        alu_p0     = ALU_SUB;
                        // Linking variants write $31 whether or not the
                        // branch is taken.
                        if (rt[4]) begin
                            rfWriteData_p0 = WD_PC8;
                            rfWriteAddr_p0 = WA_R31;
                            rfWen_p0       = 1'b1;
                        end
                    end
                    default: reserved_p0 = 1'b1;
                endcase
            end
            6'h02: pcValue_p0 = PC_JUMP;
            6'h03: begin
                pcValue_p0     = PC_JUMP;
                rfWriteData_p0 = WD_PC8;
                rfWriteAddr_p0 = WA_R31;
                rfWen_p0       = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                // Datapath gates this select with the compare outcome.
                pcValue_p0 = PC_BRANCH;
                aluSrc1_p0 = SRC1_RS;
                aluSrc2_p0 = opcode[1] ? SRC2_ZERO : SRC2_RT;
                alu_p0     = ALU_SUB;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                aluSrc1_p0     = SRC1_RS;
                rfWriteAddr_p0 = WA_RT;
                rfWen_p0       = 1'b1;
                case (opcode)
                    6'h08, 6'h09: begin aluSrc2_p0 = SRC2_SEXT; alu_p0 = ALU_ADD;  end
                    6'h0A:        begin aluSrc2_p0 = SRC2_SEXT; alu_p0 = ALU_SLT;  end
                    6'h0B:        begin aluSrc2_p0 = SRC2_SEXT; alu_p0 = ALU_SLTU; end
                    6'h0C:        begin aluSrc2_p0 = SRC2_ZEXT; alu_p0 = ALU_AND;  end
                    6'h0D:        begin aluSrc2_p0 = SRC2_ZEXT; alu_p0 = ALU_OR;   end
                    default:      begin aluSrc2_p0 = SRC2_ZEXT; alu_p0 = ALU_XOR;  end
                endcase
            end
            6'h0F: begin
                // LUI: immediate shifted left by a constant 16.
                aluSrc1_p0     = SRC1_C16;
                aluSrc2_p0     = SRC2_ZEXT;
                alu_p0         = ALU_SLL;
                rfWriteAddr_p0 = WA_RT;
                rfWen_p0       = 1'b1;
            end
            6'h20, 6'h23, 6'h24: begin
                aluSrc1_p0     = SRC1_RS;
                aluSrc2_p0     = SRC2_SEXT;
                alu_p0         = ALU_ADD;
                dataRamEn_p0   = 1'b1;
                tempWen_p0     = 1'b1;
                rfWriteData_p0 = WD_MEM;
                rfWriteAddr_p0 = WA_RT;
                rfWen_p0       = 1'b1;
            end
            6'h28, 6'h2B: begin
                aluSrc1_p0    = SRC1_RS;
                aluSrc2_p0    = SRC2_SEXT;
                alu_p0        = ALU_ADD;
                dataRamEn_p0  = 1'b1;
                dataRamWen_p0 = 1'b1;
            end
            default: reserved_p0 = 1'b1;
        endcase

        // Reserved paths leave every select and enable at its default, so
        // only the PC choice differs between builds.
`ifdef CPU_DEC_TRAP_EN
        if (reserved_p0) begin
            pcValue_p0 = PC_TRAP;
        end
`else
        if (reserved_p0) begin
            pcValue_p0 = PC_PLUS4;
        end
`endif
    end

    // ---- stage p1: registered control outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_pcValue_mux     <= '0;
            ctl_instRam_en      <= 1'b0;
            ctl_aluSrc1_mux     <= '0;
            ctl_aluSrc2_mux     <= '0;
            ctl_alu_mux         <= '0;
            ctl_dataRam_en      <= 1'b0;
            ctl_dataRam_wen     <= 1'b0;
            ctl_rfWriteData_mux <= '0;
            ctl_rfWriteAddr_mux <= '0;
            ctl_rf_wen          <= 1'b0;
            ctl_low_wen         <= 1'b0;
            ctl_high_wen        <= 1'b0;
            ctl_temp_wen        <= 1'b0;
        end else begin
            ctl_pcValue_mux     <= pcValue_p0;
            ctl_instRam_en      <= 1'b1;
            ctl_aluSrc1_mux     <= aluSrc1_p0;
            ctl_aluSrc2_mux     <= aluSrc2_p0;
            ctl_alu_mux         <= alu_p0;
            ctl_dataRam_en      <= dataRamEn_p0;
            ctl_dataRam_wen     <= dataRamWen_p0;
            ctl_rfWriteData_mux <= rfWriteData_p0;
            ctl_rfWriteAddr_mux <= rfWriteAddr_p0;
            ctl_rf_wen          <= rfWen_p0;
            ctl_low_wen         <= lowWen_p0;
            ctl_high_wen        <= highWen_p0;
            ctl_temp_wen        <= tempWen_p0;
        end
    end

    // Instruction memory is never written by the CPU.
    assign ctl_instRam_wen = 1'b0;

endmodule

// File: tb/tb_cpu_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_decoder
//
// Self-checking bench for cpu_ctrl_decoder. Each driven instruction pushes
// its expected output vector (from an independent class-based reference
// model) onto a scoreboard queue; the entry is popped and compared after the
// next rising edge. Trap behaviour follows CPU_DEC_TRAP_EN when defined.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [5:0] rt;
    logic [4:0] pcMux;
    logic       instEn;
    logic       instWen;
    logic [2:0] src1Mux;
    logic [3:0] src2Mux;
    logic [8:0] aluMux;
    logic       dEn;
    logic       dWen;
    logic [2:0] wdMux;
    logic [2:0] waMux;
    logic       rfWen;
    logic       loWen;
    logic       hiWen;
    logic       tmpWen;
    logic [34:0] obs;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic [34:0] exp;
        string       name;
    } sbEntry_t;
    sbEntry_t sb[$];

    always #5 clk = ~clk;

    cpu_ctrl_decoder dut (
        .clk                 (clk),
        .rst                 (rst),
        .opcode              (opcode),
        .funct               (funct),
        .rt                  (rt),
        .ctl_pcValue_mux     (pcMux),
        .ctl_instRam_en      (instEn),
        .ctl_instRam_wen     (instWen),
        .ctl_aluSrc1_mux     (src1Mux),
        .ctl_aluSrc2_mux     (src2Mux),
        .ctl_alu_mux         (aluMux),
        .ctl_dataRam_en      (dEn),
        .ctl_dataRam_wen     (dWen),
        .ctl_rfWriteData_mux (wdMux),
        .ctl_rfWriteAddr_mux (waMux),
        .ctl_rf_wen          (rfWen),
        .ctl_low_wen         (loWen),
        .ctl_high_wen        (hiWen),
        .ctl_temp_wen        (tmpWen)
    );

    assign obs = {pcMux, instEn, instWen, src1Mux, src2Mux, aluMux, dEn, dWen,
                  wdMux, waMux, rfWen, loWen, hiWen, tmpWen};

    // Reference model organised by instruction class.
    function automatic logic [34:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [5:0] rtv, input logic rstv);
        logic [4:0] r5;
        bit r, ri, aluR, sll, jr, jalr, mfhi, mflo, mthi, mtlo, mult;
        bit bz, bzal, j, jal, beq, blez, addi, slti, sltiu, logi, lui, ld, st, valid;
        logic [4:0] pc;
        logic [2:0] s1, wd, wa;
        logic [3:0] s2;
        logic [8:0] alu;
        if (rstv) return '0;
        r5    = rtv[4:0];
        r     = (op == 6'h00);
        ri    = (op == 6'h01);
        aluR  = r && (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B});
        sll   = r && fn == 6'h00;
        jr    = r && fn == 6'h08;
        jalr  = r && fn == 6'h09;
        mfhi  = r && fn == 6'h10;
        mthi  = r && fn == 6'h11;
        mflo  = r && fn == 6'h12;
        mtlo  = r && fn == 6'h13;
        mult  = r && (fn == 6'h18 || fn == 6'h19);
        bz    = ri && (r5 == 5'h00 || r5 == 5'h01);
        bzal  = ri && (r5 == 5'h10 || r5 == 5'h11);
        j     = op == 6'h02;
        jal   = op == 6'h03;
        beq   = op == 6'h04 || op == 6'h05;
        blez  = op == 6'h06 || op == 6'h07;
        addi  = op == 6'h08 || op == 6'h09;
        slti  = op == 6'h0A;
        sltiu = op == 6'h0B;
        logi  = op inside {6'h0C, 6'h0D, 6'h0E};
        lui   = op == 6'h0F;
        ld    = op inside {6'h20, 6'h23, 6'h24};
        st    = op inside {6'h28, 6'h2B};
        valid = aluR | sll | jr | jalr | mfhi | mthi | mflo | mtlo | mult | bz | bzal |
                j | jal | beq | blez | addi | slti | sltiu | logi | lui | ld | st;

        if (bz | bzal | beq | blez)  pc = 5'b00010;
        else if (j | jal)            pc = 5'b00100;
        else if (jr | jalr)          pc = 5'b01000;
        else if (valid)              pc = 5'b00001;
`ifdef CPU_DEC_TRAP_EN
        else                         pc = 5'b10000;
`else
        else                         pc = 5'b00001;
`endif
        if (sll)       s1 = 3'b010;
        else if (lui)  s1 = 3'b100;
        else if (aluR | bz | bzal | beq | blez | addi | slti | sltiu | logi | ld | st) s1 = 3'b001;
        else           s1 = 3'b000;

        if (aluR | sll | beq)                     s2 = 4'b0001;
        else if (addi | slti | sltiu | ld | st)   s2 = 4'b0010;
        else if (logi | lui)                      s2 = 4'b0100;
        else if (bz | bzal | blez)                s2 = 4'b1000;
        else                                      s2 = 4'b0000;

        alu = '0;
        alu[0] = (aluR && fn inside {6'h20, 6'h21}) | addi | ld | st;
        alu[1] = (aluR && fn inside {6'h22, 6'h23}) | bz | bzal | beq | blez;
        alu[2] = (aluR && fn == 6'h2A) | slti;
        alu[3] = (aluR && fn == 6'h2B) | sltiu;
        alu[4] = (aluR && fn == 6'h24) | (op == 6'h0C);
        alu[5] = (aluR && fn == 6'h25) | (op == 6'h0D);
        alu[6] = (aluR && fn == 6'h26) | (op == 6'h0E);
        alu[7] = (aluR && fn == 6'h27);
        alu[8] = sll | lui;

        if (ld)                      wd = 3'd1;
        else if (jalr | bzal | jal)  wd = 3'd2;
        else if (mfhi)               wd = 3'd3;
        else if (mflo)               wd = 3'd4;
        else                         wd = 3'd0;

        if (aluR | sll | jalr | mfhi | mflo)              wa = 3'b001;
        else if (addi | slti | sltiu | logi | lui | ld)   wa = 3'b010;
        else if (bzal | jal)                              wa = 3'b100;
        else                                              wa = 3'b000;

        return {pc, 1'b1, 1'b0, s1, s2, alu, ld | st, st, wd, wa, wa != 3'b000,
                mtlo | mult, mthi | mult, ld};
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic [5:0] rtv, input string nm);
        sbEntry_t e;
        rst = r; opcode = op; funct = fn; rt = rtv;
        e.exp  = model(op, fn, rtv, r);
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sbEntry_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 6'h23, 6'h21, 6'h11, "reset");
            e = sb.pop_front();
            testsRun++;
            if (obs !== e.exp || obs !== 35'd0) begin
                failCount++;
                $display("FAIL %s: got %h required %h", e.name, obs, 35'd0);
            end
        end
    endtask

    task automatic test_release();
        sbEntry_t e;
        drive(1'b0, 6'h00, 6'h00, 6'h00, "release_nop");
        e = sb.pop_front();
        testsRun++;
        if (obs !== e.exp) begin
            failCount++;
            $display("FAIL %s: got %h required %h", e.name, obs, e.exp);
        end
        testsRun++;
        if (pcMux !== 5'b00001 || instEn !== 1'b1 || src1Mux !== 3'b010 ||
            aluMux !== 9'h100 || rfWen !== 1'b1) begin
            failCount++;
            $display("FAIL release_fields: got pc=%b en=%b s1=%b alu=%h rf=%b required pc=00001 en=1 s1=010 alu=100 rf=1",
                     pcMux, instEn, src1Mux, aluMux, rfWen);
        end
    endtask

    task automatic test_special();
        logic [5:0] fns[$] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12,
                               6'h13, 6'h18, 6'h19, 6'h0C, 6'h0D, 6'h01, 6'h3F};
        sbEntry_t e;
        foreach (fns[k]) begin
            drive(1'b0, 6'h00, fns[k], 6'($urandom_range(0, 63)), "special");
            e = sb.pop_front();
            testsRun++;
            if (obs !== e.exp) begin
                failCount++;
                $display("FAIL %s fn=%h: got %h required %h", e.name, fns[k], obs, e.exp);
            end
            if (fns[k] == 6'h21) begin
                testsRun++;
                if (src1Mux !== 3'b001 || src2Mux !== 4'b0001 || aluMux !== 9'h001 ||
                    waMux !== 3'b001 || wdMux !== 3'd0 || rfWen !== 1'b1) begin
                    failCount++;
                    $display("FAIL addu_fields: got s1=%b s2=%b alu=%h wa=%b wd=%0d rf=%b", src1Mux,
                             src2Mux, aluMux, waMux, wdMux, rfWen);
                end
            end
            if (fns[k] == 6'h2B) begin
                testsRun++;
                if (aluMux !== 9'h008) begin
                    failCount++;
                    $display("FAIL sltu_alu: got %h required 008", aluMux);
                end
            end
            if (fns[k] == 6'h18) begin
                testsRun++;
                if (hiWen !== 1'b1 || loWen !== 1'b1 || rfWen !== 1'b0) begin
                    failCount++;
                    $display("FAIL mult_wen: got hi=%b lo=%b rf=%b required 1 1 0", hiWen, loWen, rfWen);
                end
            end
        end
    endtask

    task automatic test_regimm_sweep();
        sbEntry_t e;
        for (int v = 0; v < 64; v++) begin
            // Reset dropped in mid-sweep must win over the decode.
            drive(v == 40, 6'h01, 6'($urandom_range(0, 63)), 6'(v), "regimm");
            e = sb.pop_front();
            testsRun++;
            if (obs !== e.exp) begin
                failCount++;
                $display("FAIL %s rt=%h: got %h required %h", e.name, v, obs, e.exp);
            end
            if (v == 6'h11 || v == 6'h31) begin
                testsRun++;
                if (pcMux !== 5'b00010 || wdMux !== 3'd2 || waMux !== 3'b100 || rfWen !== 1'b1) begin
                    failCount++;
                    $display("FAIL bgezal_fields rt=%h: got pc=%b wd=%0d wa=%b rf=%b", v, pcMux, wdMux, waMux, rfWen);
                end
            end
        end
    endtask

    task automatic test_opcodes();
        sbEntry_t e;
        for (int v = 0; v < 64; v++) begin
            drive(1'b0, 6'(v), 6'h2A, 6'($urandom_range(0, 63)), "opcode");
            e = sb.pop_front();
            testsRun++;
            if (obs !== e.exp) begin
                failCount++;
                $display("FAIL %s op=%h: got %h required %h", e.name, v, obs, e.exp);
            end
            if (v == 6'h23) begin
                testsRun++;
                if (dEn !== 1'b1 || dWen !== 1'b0 || tmpWen !== 1'b1 || wdMux !== 3'd1 || waMux !== 3'b010) begin
                    failCount++;
                    $display("FAIL lw_fields: got den=%b dwen=%b tmp=%b wd=%0d wa=%b", dEn, dWen, tmpWen, wdMux, waMux);
                end
            end
            if (v == 6'h2B) begin
                testsRun++;
                if (dWen !== 1'b1 || rfWen !== 1'b0 || dEn !== 1'b1) begin
                    failCount++;
                    $display("FAIL sw_fields: got dwen=%b rf=%b den=%b required 1 0 1", dWen, rfWen, dEn);
                end
            end
        end
    endtask

    task automatic test_reserved();
        logic [5:0] ops[3] = '{6'h3F, 6'h00, 6'h00};
        logic [5:0] fns[3] = '{6'h00, 6'h0C, 6'h0D};
        logic [4:0] pcReq;
`ifdef CPU_DEC_TRAP_EN
        pcReq = 5'b10000;
`else
        pcReq = 5'b00001;
`endif
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, ops[k], fns[k], 6'h00, "reserved");
            void'(sb.pop_front());
            testsRun++;
            if (pcMux !== pcReq || instEn !== 1'b1 || rfWen !== 1'b0 || dEn !== 1'b0 ||
                dWen !== 1'b0 || hiWen !== 1'b0 || loWen !== 1'b0 || tmpWen !== 1'b0) begin
                failCount++;
                $display("FAIL reserved op=%h fn=%h: got pc=%b en=%b obs=%h required pc=%b, no enables",
                         ops[k], fns[k], pcMux, instEn, obs, pcReq);
            end
        end
    endtask

    task automatic test_back_to_back();
        sbEntry_t e;
        logic [5:0] ops[$] = '{6'h00, 6'h01, 6'h03, 6'h04, 6'h07, 6'h09, 6'h0E, 6'h0F,
                               6'h20, 6'h24, 6'h28, 6'h2B, 6'h12, 6'h3A};
        for (int i = 0; i < 150; i++) begin
            drive(($urandom_range(0, 29) == 0), ops[$urandom_range(0, ops.size() - 1)],
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "b2b");
            e = sb.pop_front();
            testsRun++;
            if (obs !== e.exp) begin
                failCount++;
                $display("FAIL %s %0d: got %h required %h (op=%h fn=%h rt=%h rst=%b)", e.name, i,
                         obs, e.exp, opcode, funct, rt, rst);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; rt = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_release();
        test_special();
        test_regimm_sweep();
        test_opcodes();
        test_reserved();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
